// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU memory stage vs. secondary (DMA/debug) port.
// Define DMEM_ARB_RR_EN for strict round-robin instead of CPU priority.
module dmem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 11,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Read tracking pipeline: bit k is stage k; owner bit 1 = DMA.
    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [MEM_LAT-1:0] own_q, own_d;
    logic               rd_issue;

`ifdef DMEM_ARB_RR_EN
    // Last-owner bit: 1 = DMA was granted last. Resets to DMA so CPU wins first.
    logic last_q, last_d;

    // Round-robin grant; on contention the port not served last wins.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && dma_req) begin
                cpu_gnt = last_q;
                dma_gnt = ~last_q;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req;
            end
        end
    end

    // Remember who was served last; idle cycles keep the previous owner.
    always_comb begin
        last_d = last_q;
        if (cpu_gnt) begin
            last_d = 1'b0;
        end else if (dma_gnt) begin
            last_d = 1'b1;
        end
    end

    // Last-owner register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    // CPU priority, except a DMA request that has waited LIMIT cycles.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (dma_req && (starve_q == LIMIT)) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    // Count consecutive denied DMA cycles, saturating at LIMIT.
    always_comb begin
        starve_d = 4'd0;
        if (dma_req && !dma_gnt) begin
            starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Steer the granted port onto the memory bus; quiet bus when idle.
    always_comb begin
        mem_en    = cpu_gnt | dma_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign rd_issue = mem_en & ~mem_we;

    // Shift issued reads toward the last stage; truncation drops the retiring stage.
    always_comb begin
        vld_d = MEM_LAT'({vld_q, rd_issue});
        own_d = MEM_LAT'({own_q, dma_gnt});
    end

    // Tracking stages; reset drops in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end

    assign cpu_rvalid = vld_q[MEM_LAT-1] & ~own_q[MEM_LAT-1];
    assign dma_rvalid = vld_q[MEM_LAT-1] &  own_q[MEM_LAT-1];
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed cases plus random traffic
// against a cycle-level reference model of the arbitration rules.
module tb_dmem_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 11;
    localparam int LAT = 3;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
    logic          mem_en, mem_we;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: who is owed read data each upcoming cycle
    // (0 none, 1 cpu, 2 dma), DMA wait length, last served port.
    int pipe[$];
    int waited;
    bit last_dma;

    logic [9:0] dg, dv, cv;
    logic [9:0] exp_dg, exp_dv, exp_cv;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw,
                         input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic dr, input logic dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic idle;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Check one cycle against the model, advance the model, move to next negedge.
    task automatic cyc;
        logic ec, ed, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        int own;
        #1;
        if (reset) begin
            pipe.delete();
            for (int i = 0; i < LAT; i++) pipe.push_back(0);
            waited = 0;
            last_dma = 1'b1;
        end
        ec = 1'b0;
        ed = 1'b0;
        if (!reset) begin
`ifdef DMEM_ARB_RR_EN
            if (cpu_req && dma_req) begin
                ec = last_dma;
                ed = !last_dma;
            end else begin
                ec = cpu_req;
                ed = dma_req;
            end
`else
            if (dma_req && (waited >= LIM || !cpu_req)) ed = 1'b1;
            else if (cpu_req) ec = 1'b1;
`endif
        end
        ewe = ec ? cpu_we : (ed ? dma_we : 1'b0);
        ea  = ec ? cpu_addr : (ed ? dma_addr : '0);
        ewd = ec ? cpu_wdata : (ed ? dma_wdata : '0);
        own = pipe[0];
        chk("cpu_gnt", cpu_gnt, ec);
        chk("dma_gnt", dma_gnt, ed);
        chk("mem_en", mem_en, ec | ed);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ewd);
        chk("cpu_rvalid", cpu_rvalid, own == 1);
        chk("dma_rvalid", dma_rvalid, own == 2);
        chk("cpu_rdata", cpu_rdata, mem_rdata);
        chk("dma_rdata", dma_rdata, mem_rdata);
        if (!reset) begin
            void'(pipe.pop_front());
            pipe.push_back(((ec | ed) && !ewe) ? (ec ? 1 : 2) : 0);
            if (dma_req && !ed) waited = (waited < LIM) ? waited + 1 : LIM;
            else waited = 0;
            if (ec) last_dma = 1'b0;
            else if (ed) last_dma = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        mem_rdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset holds off a pending CPU request; release grants it at once.
        cpu_req = 1'b1;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("rel_cpu_gnt", cpu_gnt, 1);
        cyc();
        idle();
        repeat (LAT + 1) cyc();

        // Both ports read continuously for 6 cycles right after reset.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(i < 6, 0, AW'($urandom), '0, i < 6, 0, AW'($urandom), '0);
            mem_rdata = $urandom;
            #1;
            dg[i] = dma_gnt;
            dv[i] = dma_rvalid;
            cv[i] = cpu_rvalid;
            cyc();
        end
`ifdef DMEM_ARB_RR_EN
        exp_dg = 10'b0000101010;
        exp_dv = 10'b0101010000;
        exp_cv = 10'b0010101000;
`else
        exp_dg = 10'b0000010000;
        exp_dv = 10'b0010000000;
        exp_cv = 10'b0101111000;
`endif
        chk("contend_dma_gnt_seq", dg, exp_dg);
        chk("contend_dma_rv_seq", dv, exp_dv);
        chk("contend_cpu_rv_seq", cv, exp_cv);

        // CPU load returns data LAT cycles after its grant.
        drive(1, 0, 11'h010, '0, 0, 0, '0, '0);
        #1;
        chk("ld_addr", mem_addr, 11'h010);
        cyc();
        idle();
        repeat (LAT - 1) cyc();
        mem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_cpu_rvalid", cpu_rvalid, 1);
        chk("ld_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("ld_dma_rvalid", dma_rvalid, 0);
        cyc();

        // DMA store at the top address never yields read data.
        drive(0, 0, '0, '0, 1, 1, 11'h7FF, 32'h12345678);
        #1;
        chk("st_en_we", {mem_en, mem_we}, 2'b11);
        chk("st_addr", mem_addr, 11'h7FF);
        chk("st_wdata", mem_wdata, 32'h12345678);
        cyc();
        idle();
        repeat (LAT + 1) begin
            #1;
            chk("st_no_rvalid", {cpu_rvalid, dma_rvalid}, 0);
            cyc();
        end

        // Reads in flight are dropped by a reset.
        drive(1, 0, 11'h123, '0, 1, 0, 11'h456, '0);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle();
        repeat (LAT + 1) begin
            #1;
            chk("rst_drop_rvalid", {cpu_rvalid, dma_rvalid}, 0);
            cyc();
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) < 3);
            drive($urandom_range(0, 9) < 7, 1'($urandom),
                  AW'($urandom), $urandom,
                  $urandom_range(0, 9) < 6, 1'($urandom),
                  AW'($urandom), $urandom);
            mem_rdata = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
